// File: rtl/axis_xy_router.sv
// axis_xy_router: five-port AXI-Stream wormhole mesh router with per-input FIFOs and XY routing
module axis_xy_router #(
  parameter int DATA_WIDTH    = 32,
  parameter int BUFFER_LENGTH = 16,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int X_WIDTH       = $clog2(MAX_ROUTERS_X),
  parameter int Y_WIDTH       = $clog2(MAX_ROUTERS_Y),
  parameter int DEST_WIDTH    = X_WIDTH + Y_WIDTH,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*DATA_WIDTH-1:0] in_tdata,
  input  logic [5*DEST_WIDTH-1:0] in_tdest,
  input  logic [4:0]              in_tlast,
  input  logic [4:0]              in_tvalid,
  output logic [4:0]              in_tready,
  output logic [5*DATA_WIDTH-1:0] out_tdata,
  output logic [5*DEST_WIDTH-1:0] out_tdest,
  output logic [4:0]              out_tlast,
  output logic [4:0]              out_tvalid,
  input  logic [4:0]              out_tready
);
  localparam int FW = DATA_WIDTH + DEST_WIDTH + 1;
  localparam int AW = $clog2(BUFFER_LENGTH);
  localparam logic [X_WIDTH-1:0] RX = X_WIDTH'(ROUTER_X);
  localparam logic [Y_WIDTH-1:0] RY = Y_WIDTH'(ROUTER_Y);
  typedef enum logic {IDLE, BUSY} state_t;
  logic [FW-1:0] head [5];
  logic [2:0] route [5];
  logic [4:0] hv, hdr, pop;
  logic [4:0] req [5];
  logic [2:0] gnt [5];
  logic [2:0] sel [5];
  state_t state_q [5];
  state_t state_d [5];
  logic [2:0] owner_q [5];
  logic [2:0] owner_d [5];
  logic [2:0] rr_q [5];
  logic [2:0] rr_d [5];
  // Flit layout in the FIFO: {last, dest, data}
  for (genvar i = 0; i < 5; i++) begin : g_in
    logic [FW-1:0] mem_q [BUFFER_LENGTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic hdr_q, push;
    logic [X_WIDTH-1:0] dx;
    logic [Y_WIDTH-1:0] dy;
    assign in_tready[i] = !rst && cnt_q != (AW+1)'(BUFFER_LENGTH);
    assign push = in_tvalid[i] && in_tready[i];
    assign hv[i] = cnt_q != '0;
    assign hdr[i] = hdr_q;
    assign head[i] = mem_q[rd_q];
    assign dx = head[i][DATA_WIDTH +: X_WIDTH];
    assign dy = head[i][DATA_WIDTH+X_WIDTH +: Y_WIDTH];
    assign route[i] = dx > RX ? 3'd3 : dx < RX ? 3'd4 : dy > RY ? 3'd2 : dy < RY ? 3'd1 : 3'd0;
    always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= {in_tlast[i], in_tdest[i*DEST_WIDTH +: DEST_WIDTH], in_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
    always_ff @(posedge clk)
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        hdr_q <= 1'b1;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop[i]) begin
          rd_q  <= rd_q + 1'b1;
          hdr_q <= head[i][FW-1];
        end
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop[i]);
      end
  end
  // Round-robin search from rr_q upward; scanning backwards lets the nearest requester win
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) req[o][i] = hv[i] && hdr[i] && route[i] == 3'(o);
      gnt[o] = rr_q[o];
      for (int k = 4; k >= 0; k--)
        if (req[o][(int'(rr_q[o]) + k) % 5]) gnt[o] = 3'((int'(rr_q[o]) + k) % 5);
      sel[o] = state_q[o] == BUSY ? owner_q[o] : gnt[o];
    end
  end
  always_comb begin
    logic xfer;
    pop = '0;
    xfer = 1'b0;
    for (int o = 0; o < 5; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      out_tvalid[o] = !rst && (state_q[o] == BUSY ? hv[sel[o]] : |req[o]);
      {out_tlast[o], out_tdest[o*DEST_WIDTH +: DEST_WIDTH], out_tdata[o*DATA_WIDTH +: DATA_WIDTH]} = head[sel[o]];
      xfer = !rst && (state_q[o] == BUSY ? hv[sel[o]] : |req[o]) && out_tready[o];
      if (xfer) pop[sel[o]] = 1'b1;
      if (xfer && state_q[o] == IDLE) begin
        rr_d[o] = gnt[o] == 3'd4 ? 3'd0 : gnt[o] + 3'd1;
        if (!head[sel[o]][FW-1]) begin
          owner_d[o] = gnt[o];
          state_d[o] = BUSY;
        end
      end
      if (xfer && state_q[o] == BUSY && head[sel[o]][FW-1]) state_d[o] = IDLE;
    end
  end
  always_ff @(posedge clk)
    for (int o = 0; o < 5; o++)
      if (rst) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
endmodule
